dual_stream_deserializer: RTL and testbench
===========================================

Name: dual_stream_deserializer

Overview:
- Sits directly downstream of the two-lane Bar-chain wrapper (Foo).
- Consumes Foo's serial outputs O0 and O1 as two bit streams sampled on a qualifier. Packs each lane LSB-first into WIDTH-bit words.
- Buffers completed word pairs in a DEPTH-entry FIFO, presented on a valid/ready interface.
- Flags per word whether the lanes agree, and keeps a sticky overflow indicator.

Parameters:
- WIDTH, 8, bits per deserialized word per lane (>=2).
- DEPTH, 4, FIFO entries (power of two, >=2).

Ports:
- CLK  input  1  sole clock; all state updates on rising edge.
- RESET  input  1  synchronous, active-high reset.
- I0  input  1  lane-0 serial bit (driven by Foo.O0).
- I1  input  1  lane-1 serial bit (driven by Foo.O1).
- in_valid  input  1  sample qualifier; I0/I1 are taken only when high.
- out_ready  input  1  consumer accepts head entry.
- out_valid  output  1  FIFO non-empty.
- out_data0  output  WIDTH  lane-0 word at FIFO head.
- out_data1  output  WIDTH  lane-1 word at FIFO head.
- out_match  output  1  head entry has out_data0 == out_data1.
- level  output  clog2(DEPTH)+1  current FIFO occupancy.
- overflow  output  1  sticky: a completed word was dropped.

Behaviour:
- Interface: one clock, CLK; reset is synchronous and active-high, RESET. No other clock or asynchronous reset exists.
- Reset (RESET high at a rising edge):
  - bit counter=0, both shift registers=0, FIFO pointers=0.
  - out_valid=0, level=0, overflow=0.
  - out_data0/out_data1/out_match are don't-care while out_valid=0; the implementation drives 0.
  - RESET asserted mid-word discards the partial word.
  - RESET asserted with FIFO content discards all entries.
  - RESET overrides all simultaneous inputs.
- Deserializer:
  - Each edge with in_valid=1 writes I0 into bit position cnt of sh0 and I1 into bit position cnt of sh1 (first sample lands in bit 0), then increments cnt.
  - in_valid=0: no change.
  - On the sample where cnt==WIDTH-1, cnt wraps to 0. The completed pair is {sh0 with bit WIDTH-1=I0, sh1 with bit WIDTH-1=I1}, and match = (word0==word1).
  - The completed pair is a push request in that same edge; there is no extra bubble. Back-to-back words need no idle cycle.
- FIFO:
  - pop = out_valid & out_ready.
  - Push succeeds if level<DEPTH, or if level==DEPTH and pop is asserted in the same cycle (simultaneous pop frees the slot).
  - If a push is requested with level==DEPTH and no pop, the word is dropped, overflow is set to 1, and stays 1 until RESET. The FIFO contents are unchanged.
  - Push and pop in the same cycle leave level unchanged.
  - Push only: level+1. Pop only: level-1.
  - Pointers are clog2(DEPTH) bits and wrap modulo DEPTH.
  - out_valid = (level!=0), registered state.
  - The head data is readable combinationally from storage at the read pointer.
- Latency: word-completing sample at edge N gives out_valid=1 after edge N when the FIFO was empty.
- out_data and out_match must hold stable while out_valid=1 and out_ready=0.
- Deserializer sampling continues regardless of out_ready; backpressure never stalls the shift path.

Test Plan:
- Reset/idle: RESET for 2 cycles with in_valid=1 and random I0/I1 -> out_valid=0, level=0, overflow=0; cnt still 0 afterwards.
- Basic word, WIDTH=8:
  - Stimulus: 8 samples with I0 bits 1,0,1,0,0,0,0,0 and I1 identical; out_ready=0.
  - Required: after 8th edge out_valid=1, out_data0=out_data1=8'h05, out_match=1, level=1.
  - Then out_ready=1 for 1 cycle -> level=0, out_valid=0.
- Mismatch plus gaps:
  - Stimulus: I0 gives 8'hA5 and I1 gives 8'h5A, with in_valid low every other cycle.
  - Required: one entry, out_data0=8'hA5, out_data1=8'h5A, out_match=0; the gaps do not advance cnt.
- Fill/overflow, DEPTH=4, out_ready=0:
  - Stimulus: 5 back-to-back words 8'h01..8'h05 on both lanes.
  - Required: level=4 after the 4th word; the 5th is dropped with overflow=1. Draining returns 01,02,03,04 in order.
  - overflow stays 1 until RESET.
- Full with simultaneous pop/push:
  - Stimulus: level=4, out_ready=1 on the same edge as the 5th word completes.
  - Required: level stays 4, overflow stays 0, head becomes word 2; 8'h05 is later read as the last entry.
- Reset mid-operation:
  - Stimulus: 3 samples of a word, plus 2 entries queued, then RESET for 1 cycle, then 8 samples of 8'hFF.
  - Required: single entry 8'hFF, level=1; no residue from the partial word.

Source files
------------

// File: rtl/dual_stream_deserializer.sv
// Two-lane serial-to-parallel deserializer with a shared word-pair FIFO.
// Each lane is packed LSB-first into WIDTH-bit words. Completed pairs go into a
// DEPTH-entry FIFO read through a valid/ready interface. Every entry carries a
// lane-agreement flag. A sticky flag records any word dropped while the FIFO was full.
module dual_stream_deserializer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic                       I0,
  input  logic                       I1,
  input  logic                       in_valid,
  input  logic                       out_ready,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_data0,
  output logic [WIDTH-1:0]           out_data1,
  output logic                       out_match,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overflow
);
  localparam int CW = $clog2(WIDTH);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_sh0, r_sh1;
  logic [WIDTH-1:0] r_mem0 [DEPTH];
  logic [WIDTH-1:0] r_mem1 [DEPTH];
  logic             r_memm [DEPTH];
  logic [AW-1:0]    r_wp, r_rp;
  logic [LW-1:0]    r_level;
  logic             r_valid;
  logic             r_ovf;

  logic [WIDTH-1:0] w_nsh0, w_nsh1;
  logic             w_last, w_push, w_pop, w_full, w_wr;
  logic [LW-1:0]    w_level_nxt;

  // Shift registers with the current sample inserted at position cnt. On the
  // last sample, these values are the completed words. They are pushed on the
  // same edge, so no bubble is inserted.
  always_comb begin
    w_nsh0 = r_sh0;
    w_nsh1 = r_sh1;
    w_nsh0[r_cnt] = I0;
    w_nsh1[r_cnt] = I1;
  end

  assign w_last = (r_cnt == CW'(WIDTH - 1));
  assign w_push = in_valid & w_last;
  assign w_pop  = r_valid & out_ready;
  assign w_full = (r_level == LW'(DEPTH));
  // A pop in the same cycle frees the head slot, so a push into a full FIFO still fits.
  assign w_wr   = w_push & (~w_full | w_pop);

  // Next occupancy: one write and one read cancel each other out.
  always_comb begin
    w_level_nxt = r_level;
    case ({w_wr, w_pop})
      2'b10:   w_level_nxt = r_level + LW'(1);
      2'b01:   w_level_nxt = r_level - LW'(1);
      default: w_level_nxt = r_level;
    endcase
  end

  // Bit counter and lane shift registers. Sampling is never stalled by backpressure.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_cnt <= '0;
      r_sh0 <= '0;
      r_sh1 <= '0;
    end else if (in_valid) begin
      r_sh0 <= w_nsh0;
      r_sh1 <= w_nsh1;
      r_cnt <= w_last ? '0 : r_cnt + CW'(1);
    end
  end

  // FIFO pointers, occupancy, the registered valid flag and the sticky overflow flag.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_level <= '0;
      r_valid <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_wr)  r_wp <= r_wp + AW'(1);
      if (w_pop) r_rp <= r_rp + AW'(1);
      r_level <= w_level_nxt;
      r_valid <= (w_level_nxt != '0);
      if (w_push & w_full & ~w_pop) r_ovf <= 1'b1;
    end
  end

  // FIFO storage. No reset is needed, because the valid flag gates the head outputs.
  always_ff @(posedge CLK) begin
    if (w_wr) begin
      r_mem0[r_wp] <= w_nsh0;
      r_mem1[r_wp] <= w_nsh1;
      r_memm[r_wp] <= (w_nsh0 == w_nsh1);
    end
  end

  assign out_valid = r_valid;
  assign out_data0 = r_valid ? r_mem0[r_rp] : '0;
  assign out_data1 = r_valid ? r_mem1[r_rp] : '0;
  assign out_match = r_valid ? r_memm[r_rp] : 1'b0;
  assign level     = r_level;
  assign overflow  = r_ovf;
endmodule

// File: tb/tb_dual_stream_deserializer.sv
// Directed bench for dual_stream_deserializer with WIDTH=8 and DEPTH=4.
module tb_dual_stream_deserializer;
  logic       CLK = 1'b0;
  logic       RESET, I0, I1, in_valid, out_ready;
  logic       out_valid, out_match, overflow;
  logic [7:0] out_data0, out_data1;
  logic [2:0] level;
  int         n_vec = 0;
  int         n_err = 0;

  dual_stream_deserializer #(.WIDTH(8), .DEPTH(4)) dut (
    .CLK(CLK), .RESET(RESET), .I0(I0), .I1(I1), .in_valid(in_valid),
    .out_ready(out_ready), .out_valid(out_valid), .out_data0(out_data0),
    .out_data1(out_data1), .out_match(out_match), .level(level),
    .overflow(overflow)
  );

  always #5 CLK = ~CLK;

  // Inputs change, and outputs are sampled, 1 time unit after the rising edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Eight back-to-back samples, LSB first. out_ready is driven only on the last sample.
  task automatic send_word(input logic [7:0] w0, input logic [7:0] w1, input logic rdy_last);
    for (int i = 0; i < 8; i++) begin
      in_valid  = 1'b1;
      I0        = w0[i];
      I1        = w1[i];
      out_ready = (i == 7) ? rdy_last : 1'b0;
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic pop_check(input string tag, input logic [7:0] exp);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_d0"}, 32'(out_data0), 32'(exp));
    chk({tag, "_d1"}, 32'(out_data1), 32'(exp));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    logic [7:0] wa, wb;
    RESET = 1'b1; in_valid = 1'b1; out_ready = 1'b0; I0 = 1'b0; I1 = 1'b0;

    // Reset held for 2 cycles while random samples are presented.
    for (int i = 0; i < 2; i++) begin
      I0 = 1'($urandom); I1 = 1'($urandom);
      tick();
    end
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_d0", 32'(out_data0), 32'd0);
    RESET = 1'b0; in_valid = 1'b0;

    // Basic word 8'h05 on both lanes. This also shows that the counter restarted at 0.
    wa = 8'h05;
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1; I0 = wa[i]; I1 = wa[i];
      tick();
    end
    chk("basic_pre_valid", 32'(out_valid), 32'd0);
    I0 = wa[7]; I1 = wa[7];
    tick();
    in_valid = 1'b0;
    chk("basic_valid", 32'(out_valid), 32'd1);
    chk("basic_d0", 32'(out_data0), 32'h05);
    chk("basic_d1", 32'(out_data1), 32'h05);
    chk("basic_match", 32'(out_match), 32'd1);
    chk("basic_level", 32'(level), 32'd1);
    tick();
    chk("basic_hold_d0", 32'(out_data0), 32'h05);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("basic_pop_level", 32'(level), 32'd0);
    chk("basic_pop_valid", 32'(out_valid), 32'd0);

    // Lane mismatch, with a gap cycle after every sample.
    wa = 8'hA5; wb = 8'h5A;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; I0 = wa[i]; I1 = wb[i];
      tick();
      in_valid = 1'b0; I0 = 1'($urandom); I1 = 1'($urandom);
      tick();
    end
    chk("mm_level", 32'(level), 32'd1);
    chk("mm_d0", 32'(out_data0), 32'hA5);
    chk("mm_d1", 32'(out_data1), 32'h5A);
    chk("mm_match", 32'(out_match), 32'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("mm_pop_level", 32'(level), 32'd0);

    // Fill to DEPTH, then overflow with a 5th word.
    for (int w = 1; w <= 4; w++) send_word(8'(w), 8'(w), 1'b0);
    chk("fill_level", 32'(level), 32'd4);
    chk("fill_ovf", 32'(overflow), 32'd0);
    send_word(8'h05, 8'h05, 1'b0);
    chk("ovf_level", 32'(level), 32'd4);
    chk("ovf_flag", 32'(overflow), 32'd1);
    for (int w = 1; w <= 4; w++) pop_check($sformatf("drain%0d", w), 8'(w));
    chk("drain_level", 32'(level), 32'd0);
    chk("drain_valid", 32'(out_valid), 32'd0);
    chk("ovf_sticky", 32'(overflow), 32'd1);

    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    chk("ovf_clr", 32'(overflow), 32'd0);

    // Full FIFO: a pop and a push on the same edge.
    for (int w = 1; w <= 4; w++) send_word(8'(w), 8'(w), 1'b0);
    send_word(8'h05, 8'h05, 1'b1);
    chk("simul_level", 32'(level), 32'd4);
    chk("simul_ovf", 32'(overflow), 32'd0);
    chk("simul_head", 32'(out_data0), 32'h02);
    for (int w = 2; w <= 5; w++) pop_check($sformatf("simul_drain%0d", w), 8'(w));
    chk("simul_empty", 32'(level), 32'd0);

    // Reset mid-operation: two queued entries plus a partial word.
    send_word(8'h11, 8'h11, 1'b0);
    send_word(8'h22, 8'h22, 1'b0);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; I0 = 1'b0; I1 = 1'b1;
      tick();
    end
    RESET = 1'b1; in_valid = 1'b1; I0 = 1'b0; I1 = 1'b1;
    tick();
    RESET = 1'b0; in_valid = 1'b0;
    chk("mid_rst_level", 32'(level), 32'd0);
    send_word(8'hFF, 8'hFF, 1'b0);
    chk("mid_level", 32'(level), 32'd1);
    chk("mid_match", 32'(out_match), 32'd1);
    pop_check("mid_ff", 8'hFF);
    chk("mid_empty", 32'(level), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
